// File: rtl/multi_alarm_ctrl.sv
// Multi-slot BCD alarm controller: per-slot enables, once-per-minute compare, RING/SNOOZE sequencing.
// Optional feature macro ALARM_BEEP_EN: alarm_sound beeps 1 s on / 1 s off while ringing.
module multi_alarm_ctrl #(
    parameter int SEL_W      = 2,
    parameter int SNOOZE_MIN = 5,
    parameter int RING_MIN   = 3,
    parameter int MAX_SNOOZE = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             one_minute,
    input  logic             one_second,
    input  logic [15:0]      current_time,
    input  logic [15:0]      new_alarm_time,
    input  logic             load_new_a,
    input  logic [SEL_W-1:0] alarm_sel,
    input  logic             en_wr,
    input  logic             en_val,
    input  logic             snooze,
    input  logic             stop,
    output logic [15:0]      alarm_time_out,
    output logic             alarm_sound,
    output logic [SEL_W-1:0] active_slot,
    output logic             ringing,
    output logic             snoozing
);
    localparam int         NUM_ALARMS   = 2**SEL_W;
    localparam logic [3:0] RING_LAST    = 4'(RING_MIN - 1);
    localparam logic [3:0] SNOOZE_LAST  = 4'(SNOOZE_MIN - 1);
    localparam logic [3:0] SNOOZE_LIMIT = 4'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_t;

    state_t                state, next_state;
    logic [15:0]           slot_time [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] slot_en;
    logic                  om_d;
    logic [3:0]            ring_cnt, snz_cnt, min_cnt;
    logic [3:0]            ring_cnt_next, snz_cnt_next, min_cnt_next;
    logic [SEL_W-1:0]      slot_next;
    logic                  match_any;
    logic [SEL_W-1:0]      match_idx;
    logic                  sound_next;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // Enable write is applied after the load so en_wr overrides the implicit enable of a load.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_ALARMS; i++) slot_time[i] <= 16'h0000;
            slot_en <= '0;
        end else begin
            if (load_new_a) begin
                slot_time[alarm_sel] <= new_alarm_time;
                slot_en[alarm_sel]   <= 1'b1;
            end
            if (en_wr) slot_en[alarm_sel] <= en_val;
        end
    end

    assign alarm_time_out = slot_time[alarm_sel];

    // The counter publishes the new minute one cycle after one_minute, hence the om_d qualifier.
    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (om_d && slot_en[i] && (slot_time[i] == current_time)) begin
                match_any = 1'b1;
                match_idx = SEL_W'(i);
            end
        end
    end

    always_comb begin
        next_state    = state;
        ring_cnt_next = ring_cnt;
        snz_cnt_next  = snz_cnt;
        min_cnt_next  = min_cnt;
        slot_next     = active_slot;
        unique case (state)
            IDLE: begin
                if (match_any) begin
                    next_state    = RING;
                    slot_next     = match_idx;
                    ring_cnt_next = '0;
                    snz_cnt_next  = '0;
                end
            end
            RING: begin
                if (stop) begin
                    next_state = IDLE;
                end else if (snooze && (snz_cnt < SNOOZE_LIMIT)) begin
                    next_state   = SNOOZE;
                    snz_cnt_next = sat_inc(snz_cnt);
                    min_cnt_next = '0;
                end else if (om_d) begin
                    ring_cnt_next = sat_inc(ring_cnt);
                    if (ring_cnt == RING_LAST) next_state = IDLE;
                end
            end
            SNOOZE: begin
                if (stop) begin
                    next_state = IDLE;
                end else if (om_d) begin
                    min_cnt_next = sat_inc(min_cnt);
                    if (min_cnt == SNOOZE_LAST) begin
                        next_state    = RING;
                        ring_cnt_next = '0;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

`ifdef ALARM_BEEP_EN
    // Beep restarts high on every entry into RING, then flips on each second.
    always_comb begin
        sound_next = 1'b0;
        if (next_state == RING) begin
            if (state != RING)   sound_next = 1'b1;
            else if (one_second) sound_next = ~alarm_sound;
            else                 sound_next = alarm_sound;
        end
    end
`else
    logic unused_one_second;
    assign unused_one_second = one_second;
    assign sound_next        = (next_state == RING);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            om_d        <= 1'b0;
            ring_cnt    <= '0;
            snz_cnt     <= '0;
            min_cnt     <= '0;
            active_slot <= '0;
            ringing     <= 1'b0;
            snoozing    <= 1'b0;
            alarm_sound <= 1'b0;
        end else begin
            state       <= next_state;
            om_d        <= one_minute;
            ring_cnt    <= ring_cnt_next;
            snz_cnt     <= snz_cnt_next;
            min_cnt     <= min_cnt_next;
            active_slot <= slot_next;
            ringing     <= (next_state == RING);
            snoozing    <= (next_state == SNOOZE);
            alarm_sound <= sound_next;
        end
    end
endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// Self-checking bench for multi_alarm_ctrl: behavioural minute-counting model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_multi_alarm_ctrl;
    localparam int SEL_W      = 2;
    localparam int NUM        = 4;
    localparam int SNOOZE_MIN = 5;
    localparam int RING_MIN   = 3;
    localparam int MAX_SNOOZE = 3;
    localparam int M_IDLE     = 0;
    localparam int M_RING     = 1;
    localparam int M_SNOOZE   = 2;

    logic             clock = 1'b0;
    logic             reset, one_minute, one_second, load_new_a, en_wr, en_val, snooze, stop;
    logic [15:0]      current_time, new_alarm_time, alarm_time_out;
    logic [SEL_W-1:0] alarm_sel, active_slot;
    logic             alarm_sound, ringing, snoozing;

    always #5 clock = ~clock;

    multi_alarm_ctrl #(
        .SEL_W(SEL_W), .SNOOZE_MIN(SNOOZE_MIN), .RING_MIN(RING_MIN), .MAX_SNOOZE(MAX_SNOOZE)
    ) dut (
        .clock(clock), .reset(reset), .one_minute(one_minute), .one_second(one_second),
        .current_time(current_time), .new_alarm_time(new_alarm_time), .load_new_a(load_new_a),
        .alarm_sel(alarm_sel), .en_wr(en_wr), .en_val(en_val), .snooze(snooze), .stop(stop),
        .alarm_time_out(alarm_time_out), .alarm_sound(alarm_sound), .active_slot(active_slot),
        .ringing(ringing), .snoozing(snoozing)
    );

    int checks_total  = 0;
    int checks_passed = 0;
    bit checking      = 1'b0;

    logic [15:0] m_slot [NUM];
    bit          m_en   [NUM];
    int          m_state, m_rung, m_snoozed, m_used, m_active;
    bit          m_sound, m_om_prev;
    logic [15:0] time_pool [4] = '{16'h0700, 16'h1230, 16'h0915, 16'h2359};

    task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks_total++;
        if (actual === expected) checks_passed++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    // Model counts minutes rung/snoozed and snoozes used per event, straight from the alarm rules.
    always @(posedge clock) begin : model
        int prev_state;
        int hit;
        prev_state = m_state;
        if (reset) begin
            for (int i = 0; i < NUM; i++) begin
                m_slot[i] = 16'h0000;
                m_en[i]   = 1'b0;
            end
            m_state = M_IDLE; m_rung = 0; m_snoozed = 0; m_used = 0; m_active = 0;
            m_sound = 1'b0; m_om_prev = 1'b0;
        end else begin
            hit = -1;
            if (m_om_prev)
                for (int i = NUM - 1; i >= 0; i--)
                    if (m_en[i] && m_slot[i] == current_time) hit = i;
            case (m_state)
                M_IDLE: if (hit >= 0) begin
                    m_state = M_RING; m_active = hit; m_rung = 0; m_used = 0;
                end
                M_RING: begin
                    if (stop) m_state = M_IDLE;
                    else if (snooze && m_used < MAX_SNOOZE) begin
                        m_state = M_SNOOZE; m_used++; m_snoozed = 0;
                    end else if (m_om_prev) begin
                        m_rung++;
                        if (m_rung == RING_MIN) m_state = M_IDLE;
                    end
                end
                M_SNOOZE: begin
                    if (stop) m_state = M_IDLE;
                    else if (m_om_prev) begin
                        m_snoozed++;
                        if (m_snoozed == SNOOZE_MIN) begin
                            m_state = M_RING; m_rung = 0;
                        end
                    end
                end
                default: m_state = M_IDLE;
            endcase
`ifdef ALARM_BEEP_EN
            if (m_state != M_RING)      m_sound = 1'b0;
            else if (prev_state != M_RING) m_sound = 1'b1;
            else if (one_second)        m_sound = !m_sound;
`else
            m_sound = (m_state == M_RING);
`endif
            if (load_new_a) begin
                m_slot[alarm_sel] = new_alarm_time;
                m_en[alarm_sel]   = 1'b1;
            end
            if (en_wr) m_en[alarm_sel] = en_val;
            m_om_prev = one_minute;
        end
    end

    always @(negedge clock) begin
        if (checking) begin
            check_output("ringing",     16'(ringing),     16'(m_state == M_RING));
            check_output("snoozing",    16'(snoozing),    16'(m_state == M_SNOOZE));
            check_output("alarm_sound", 16'(alarm_sound), 16'(m_sound));
            check_output("active_slot", 16'(active_slot), 16'(m_active));
            check_output("alarm_time_out", alarm_time_out, m_slot[alarm_sel]);
        end
    end

    task automatic apply_stimulus(input int cycles);
        repeat (cycles) begin
            @(posedge clock);
            #1;
            one_minute = 1'b0; one_second = 1'b0; load_new_a = 1'b0;
            en_wr = 1'b0; snooze = 1'b0; stop = 1'b0;
        end
    endtask

    task automatic minute_pulse();
        one_minute = 1'b1;
        apply_stimulus(2);
    endtask

    task automatic load_slot(input logic [SEL_W-1:0] sel, input logic [15:0] t);
        alarm_sel = sel; new_alarm_time = t; load_new_a = 1'b1;
        apply_stimulus(1);
    endtask

    initial begin
        reset = 1'b1; one_minute = 1'b0; one_second = 1'b0; load_new_a = 1'b0; en_wr = 1'b0;
        en_val = 1'b0; snooze = 1'b0; stop = 1'b0; current_time = 16'h0000;
        new_alarm_time = 16'h0000; alarm_sel = '0;
        apply_stimulus(3);
        reset = 1'b0;
        checking = 1'b1;
        check_output("reset_ringing", 16'(ringing), 16'd0);
        check_output("reset_snoozing", 16'(snoozing), 16'd0);
        check_output("reset_sound", 16'(alarm_sound), 16'd0);
        check_output("reset_slot", 16'(active_slot), 16'd0);

        current_time = 16'h1230;
        load_slot(2'd1, 16'h1230);
        apply_stimulus(1);
        check_output("load_equal_no_ring", 16'(ringing), 16'd0);
        check_output("readback_slot1", alarm_time_out, 16'h1230);
        one_minute = 1'b1;
        apply_stimulus(1);
        check_output("ring_latency_one", 16'(ringing), 16'd0);
        apply_stimulus(1);
        check_output("ring_1230", 16'(ringing), 16'd1);
        check_output("active_1230", 16'(active_slot), 16'd1);
        stop = 1'b1;
        apply_stimulus(1);
        check_output("stop_ring", 16'(ringing), 16'd0);

        load_slot(2'd0, 16'h0700);
        load_slot(2'd2, 16'h0700);
        current_time = 16'h0700;
        minute_pulse();
        check_output("priority_low", 16'(active_slot), 16'd0);
        stop = 1'b1;
        apply_stimulus(1);
        alarm_sel = 2'd0; en_val = 1'b0; en_wr = 1'b1;
        apply_stimulus(1);
        minute_pulse();
        check_output("priority_disabled", 16'(active_slot), 16'd2);
        check_output("ring_slot2", 16'(ringing), 16'd1);

        current_time = 16'h0701;
        for (int s = 0; s < MAX_SNOOZE; s++) begin
            snooze = 1'b1;
            apply_stimulus(1);
            check_output("snooze_enter", 16'(snoozing), 16'd1);
            repeat (SNOOZE_MIN - 1) minute_pulse();
            check_output("snooze_hold", 16'(snoozing), 16'd1);
            minute_pulse();
            check_output("snooze_rering", 16'(ringing), 16'd1);
        end
        snooze = 1'b1;
        apply_stimulus(1);
        check_output("snooze_limit_ring", 16'(ringing), 16'd1);
        check_output("snooze_limit_snz", 16'(snoozing), 16'd0);

        repeat (RING_MIN - 1) minute_pulse();
        check_output("autostop_before", 16'(ringing), 16'd1);
        minute_pulse();
        check_output("autostop_ring", 16'(ringing), 16'd0);
        check_output("autostop_sound", 16'(alarm_sound), 16'd0);

        current_time = 16'h0700;
        minute_pulse();
        stop = 1'b1; snooze = 1'b1;
        apply_stimulus(1);
        check_output("stop_snooze_ring", 16'(ringing), 16'd0);
        check_output("stop_snooze_snz", 16'(snoozing), 16'd0);

        minute_pulse();
        snooze = 1'b1;
        apply_stimulus(1);
        check_output("pre_reset_snz", 16'(snoozing), 16'd1);
        reset = 1'b1;
        apply_stimulus(1);
        reset = 1'b0;
        alarm_sel = 2'd2;
        #1;
        check_output("reset_snz_snoozing", 16'(snoozing), 16'd0);
        check_output("reset_snz_ringing", 16'(ringing), 16'd0);
        check_output("reset_snz_slot", alarm_time_out, 16'h0000);

        for (int c = 0; c < 4000; c++) begin
            reset      = ($urandom % 400) == 0;
            one_minute = ($urandom % 5) == 0;
            one_second = ($urandom % 3) == 0;
            if (($urandom % 30) == 0) current_time = time_pool[$urandom % 4];
            alarm_sel      = SEL_W'($urandom % NUM);
            new_alarm_time = time_pool[$urandom % 4];
            load_new_a     = ($urandom % 15) == 0;
            en_wr          = ($urandom % 20) == 0;
            en_val         = ($urandom % 4) != 0;
            snooze         = ($urandom % 8) == 0;
            stop           = ($urandom % 40) == 0;
            @(posedge clock);
            #1;
        end
        reset = 1'b0;
        apply_stimulus(2);
        checking = 1'b0;
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
